// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared types for the sequential MAC layer. It holds the FSM
//                state enum, the activation-mode enum and the accumulator
//                width helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  typedef enum logic {
    ACT_IDENTITY = 1'b0,
    ACT_RELU     = 1'b1
  } act_mode_e;

  // Full signed product, plus enough headroom for NumInputs products and
  // the bias, so that the sum can never overflow.
  function automatic int acc_width(input int dw, input int ni);
    return 2 * dw + $clog2(ni + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lane
//  Description : Datapath for one neuron. It holds the accumulator and applies
//                the bias add, the fixed-point shift, saturation and optional
//                ReLU. The result is kept in a register.
//  Ports       : clk_i/reset_i  clock, synchronous active-low reset
//                clear_i        zero the accumulator (input transfer)
//                mac_en_i       accumulate w_i*x_i this cycle
//                act_en_i       register the activated result
//                w_i/x_i/bias_i signed weight, activation and bias
//                mode_i         identity / ReLU
//                actv_o         registered DataWidth-bit result
//  Revision    : 1.0  initial release
// ============================================================================
module mac_lane
  import nn_pkg::*;
#(
  parameter int NumInputs = 4,
  parameter int DataWidth = 8,
  parameter int FracBits  = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clear_i,
  input  logic                        mac_en_i,
  input  logic                        act_en_i,
  input  logic signed [DataWidth-1:0] w_i,
  input  logic signed [DataWidth-1:0] x_i,
  input  logic signed [DataWidth-1:0] bias_i,
  input  act_mode_e                   mode_i,
  output logic signed [DataWidth-1:0] actv_o
);

  localparam int AccW = acc_width(DataWidth, NumInputs);
  localparam int SumW = AccW + 1;
  localparam logic signed [SumW-1:0] MaxV = SumW'((2 ** (DataWidth - 1)) - 1);
  localparam logic signed [SumW-1:0] MinV = ~MaxV;

  logic signed [AccW-1:0]        acc_q, acc_d;
  logic signed [DataWidth-1:0]   actv_q, res_d;
  logic signed [2*DataWidth-1:0] prod;
  logic signed [SumW-1:0]        bias_sh, sum, shifted;

  assign prod  = w_i * x_i;
  assign acc_d = acc_q + {{(AccW - 2*DataWidth){prod[2*DataWidth-1]}}, prod};

  // The bias is aligned to the accumulator's fixed-point position before the
  // add, and the whole sum is shifted back down afterwards.
  assign bias_sh = {{(SumW - DataWidth){bias_i[DataWidth-1]}}, bias_i} <<< FracBits;
  assign sum     = {acc_q[AccW-1], acc_q} + bias_sh;
  assign shifted = sum >>> FracBits;

  always_comb begin
    res_d = shifted[DataWidth-1:0];
    if (shifted > MaxV) begin
      res_d = MaxV[DataWidth-1:0];
    end else if (shifted < MinV) begin
      res_d = MinV[DataWidth-1:0];
    end
    if (mode_i == ACT_RELU && res_d[DataWidth-1]) begin
      res_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      acc_q  <= '0;
      actv_q <= '0;
    end else begin
      if (clear_i) begin
        acc_q <= '0;
      end else if (mac_en_i) begin
        acc_q <= acc_d;
      end
      if (act_en_i) begin
        actv_q <= res_d;
      end
    end
  end

  assign actv_o = actv_q;

endmodule
`default_nettype wire

// File: rtl/mac_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mac_layer_seq
//  Description : A sequential fully-connected layer. It performs one input
//                element per cycle across all neurons in parallel. Weights and
//                biases are loaded through a shift-register scan chain.
//  Ports       : clk_i/reset_i   clock, synchronous active-low reset
//                actv_i,req_i,ack_o     input vector and handshake
//                actv_o,req_o,ack_i     result vector and handshake
//                act_mode_i      0 identity, 1 ReLU (captured on transfer)
//                shift_i,scan_di,scan_do  weight scan chain
//                busy_o          high whenever not idle
//  Revision    : 1.0  initial release
// ============================================================================
module mac_layer_seq
  import nn_pkg::*;
#(
  parameter int NumInputs  = 4,
  parameter int NumNeurons = 4,
  parameter int DataWidth  = 8,
  parameter int FracBits   = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [DataWidth*NumInputs-1:0]  actv_i,
  input  logic                            req_i,
  output logic                            ack_o,
  output logic [DataWidth*NumNeurons-1:0] actv_o,
  output logic                            req_o,
  input  logic                            ack_i,
  input  logic                            act_mode_i,
  input  logic                            shift_i,
  input  logic [DataWidth-1:0]            scan_di,
  output logic [DataWidth-1:0]            scan_do,
  output logic                            busy_o
);

  localparam int Slots   = NumInputs + 1;
  localparam int NumRegs = NumNeurons * Slots;
  localparam int CntW    = $clog2(NumInputs + 1);

  state_e                       state_q, state_d;
  logic [CntW-1:0]              j_q, j_d;
  logic                         req_q, req_d;
  logic [DataWidth*NumInputs-1:0] x_q;
  act_mode_e                    mode_q;
  logic [DataWidth-1:0]         wreg_q [NumRegs];
  logic [DataWidth-1:0]         x_sel;
  logic                         in_xfer, shift_en;

  assign ack_o    = (state_q == ST_IDLE) & ~shift_i;
  assign in_xfer  = req_i & ack_o;
  assign shift_en = shift_i & (state_q == ST_IDLE);
  assign busy_o   = (state_q != ST_IDLE);
  assign req_o    = req_q;
  assign scan_do  = wreg_q[NumRegs-1];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      req_q   <= req_d;
    end
  end

  // OUT spends one cycle raising req_o, so that the result is already stable
  // when the request becomes visible.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          state_d = ST_MAC;
          j_d     = '0;
        end
      end
      ST_MAC: begin
        if (j_q == CntW'(NumInputs - 1)) begin
          state_d = ST_ACT;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_ACT: state_d = ST_OUT;
      ST_OUT: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (ack_i) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      x_q    <= '0;
      mode_q <= ACT_IDENTITY;
    end else if (in_xfer) begin
      x_q    <= actv_i;
      mode_q <= act_mode_e'(act_mode_i);
    end
  end

  // Scan chain: reg[0] takes new data, and the last register drives scan_do.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int k = 0; k < NumRegs; k++) wreg_q[k] <= '0;
    end else if (shift_en) begin
      wreg_q[0] <= scan_di;
      for (int k = 1; k < NumRegs; k++) wreg_q[k] <= wreg_q[k-1];
    end
  end

  always_comb begin
    x_sel = '0;
    for (int s = 0; s < NumInputs; s++) begin
      if (j_q == CntW'(s)) x_sel = x_q[s*DataWidth +: DataWidth];
    end
  end

  generate
    for (genvar n = 0; n < NumNeurons; n++) begin : g_lane
      logic [DataWidth-1:0] w_sel;
      logic [DataWidth-1:0] lane_out;

      always_comb begin
        w_sel = '0;
        for (int s = 0; s < NumInputs; s++) begin
          if (j_q == CntW'(s)) w_sel = wreg_q[n*Slots + s];
        end
      end

      mac_lane #(
        .NumInputs (NumInputs),
        .DataWidth (DataWidth),
        .FracBits  (FracBits)
      ) u_lane (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (in_xfer),
        .mac_en_i (state_q == ST_MAC),
        .act_en_i (state_q == ST_ACT),
        .w_i      (w_sel),
        .x_i      (x_sel),
        .bias_i   (wreg_q[n*Slots + NumInputs]),
        .mode_i   (mode_q),
        .actv_o   (lane_out)
      );

      assign actv_o[n*DataWidth +: DataWidth] = lane_out;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mac_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_layer_seq
//  Description : Self-checking bench for mac_layer_seq with 3 inputs,
//                2 neurons, 8-bit data and no fraction bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mac_layer_seq;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [23:0] actv_i = '0;
  logic        req_i = 1'b0;
  logic        ack_o;
  logic [15:0] actv_o;
  logic        req_o;
  logic        ack_i = 1'b0;
  logic        act_mode_i = 1'b0;
  logic        shift_i = 1'b0;
  logic [7:0]  scan_di = '0;
  logic [7:0]  scan_do;
  logic        busy_o;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  mac_layer_seq #(
    .NumInputs  (3),
    .NumNeurons (2),
    .DataWidth  (8),
    .FracBits   (0)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .actv_i     (actv_i),
    .req_i      (req_i),
    .ack_o      (ack_o),
    .actv_o     (actv_o),
    .req_o      (req_o),
    .ack_i      (ack_i),
    .act_mode_i (act_mode_i),
    .shift_i    (shift_i),
    .scan_di    (scan_di),
    .scan_do    (scan_do),
    .busy_o     (busy_o)
  );

  typedef struct {
    string       name;
    logic [63:0] words;  // word i shifted i-th; word 0 ends at neuron1 bias
    logic [23:0] x;      // {x2, x1, x0}
    logic        mode;
    logic [15:0] exp;    // {n1, n0}
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic load(input logic [63:0] words);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      shift_i = 1'b1;
      scan_di = words[i*8 +: 8];
    end
    @(negedge clk);
    shift_i = 1'b0;
  endtask

  task automatic run_inf(input string nm, input logic [23:0] x, input logic mode,
                         input logic [15:0] exp);
    int edges;
    logic [15:0] held;
    @(negedge clk);
    actv_i     = x;
    act_mode_i = mode;
    req_i      = 1'b1;
    check({nm, "_ack_o"}, {31'd0, ack_o}, 32'd1);
    @(posedge clk);
    #1 req_i = 1'b0;
    edges = 0;
    while (!req_o && edges < 20) begin
      @(posedge clk);
      #1 edges++;
    end
    check({nm, "_latency"}, edges, 32'd5);
    check({nm, "_actv"}, {16'd0, actv_o}, {16'd0, exp});
    held = actv_o;
    @(negedge clk);
    ack_i = 1'b1;
    @(posedge clk);
    #1 ack_i = 1'b0;
    check({nm, "_idle"}, {30'd0, req_o, busy_o}, 32'd0);
    @(negedge clk);
    check({nm, "_hold"}, {16'd0, actv_o}, {16'd0, held});
  endtask

  initial begin
    int n;
    logic seen;
    vecs[0] = '{"load",  {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'h00},
                {8'd1, 8'd1, 8'd1}, 1'b0, 16'hFD0A};
    vecs[1] = '{"relu",  {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'h00},
                {8'd1, 8'd1, 8'd1}, 1'b1, 16'h000A};
    vecs[2] = '{"satpos", {8{8'h7F}}, {3{8'h7F}}, 1'b0, 16'h7F7F};
    vecs[3] = '{"satneg", {8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80, 8'h80, 8'h00},
                {3{8'h7F}}, 1'b0, 16'h8080};
    // n0: 2*10 - 3*20 + 4*30 - 5 = 75 ; n1: 20 - 100 = -80
    vecs[4] = '{"mixed", {8'h02, 8'hFD, 8'h04, 8'hFB, 8'h00, 8'h01, 8'h00, 8'h9C},
                {8'd30, 8'd20, 8'd10}, 1'b0, 16'hB04B};
    vecs[5] = '{"mixrelu", {8'h02, 8'hFD, 8'h04, 8'hFB, 8'h00, 8'h01, 8'h00, 8'h9C},
                {8'd30, 8'd20, 8'd10}, 1'b1, 16'h004B};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'd0, req_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_actv", {16'd0, actv_o}, 32'd0);
    check("rst_scan", {24'd0, scan_do}, 32'd0);
    reset_i = 1'b1;
    @(negedge clk);
    check("rst_ack", {31'd0, ack_o}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].words);
      run_inf(vecs[v].name, vecs[v].x, vecs[v].mode, vecs[v].exp);
    end

    // Backpressure: ack_i during MAC is ignored. Then hold off five cycles
    // while trying to shift.
    load(vecs[0].words);
    @(negedge clk);
    actv_i = {8'd1, 8'd1, 8'd1};
    act_mode_i = 1'b0;
    req_i = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
    ack_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 ack_i = 1'b0;
    n = 0;
    while (!req_o && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_req_rise", {31'd0, req_o}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ack_o", {31'd0, ack_o}, 32'd0);
      check("bp_stable", {15'd0, req_o, actv_o}, {15'd0, 1'b1, 16'hFD0A});
      shift_i = 1'b1;
      scan_di = 8'h55;
    end
    @(negedge clk);
    shift_i = 1'b0;
    ack_i = 1'b1;
    @(posedge clk);
    #1 ack_i = 1'b0;
    check("bp_done", {30'd0, req_o, busy_o}, 32'd0);
    run_inf("bp_frozen", {8'd1, 8'd1, 8'd1}, 1'b0, 16'hFD0A);

    // Reset during MAC cycle 2
    @(negedge clk);
    actv_i = {8'd1, 8'd1, 8'd1};
    req_i = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(posedge clk);
    #1 reset_i = 1'b1;
    check("abort_ack", {31'd0, ack_o}, 32'd1);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (req_o) seen = 1'b1;
    end
    check("abort_no_req", {31'd0, seen}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_wzero", {24'd0, scan_do}, 32'd0);
      shift_i = 1'b1;
      scan_di = 8'h00;
    end
    @(negedge clk);
    shift_i = 1'b0;

    // Scan readback
    load({8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("scan_rb", {24'd0, scan_do}, 32'h11 + i);
      shift_i = 1'b1;
      scan_di = 8'h00;
    end
    @(negedge clk);
    shift_i = 1'b0;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
`default_nettype wire
